banked_mmio_memory: RTL and testbench

Parametrised data-memory controller for the RiscBEE core: byte-addressed four-bank RAM with misaligned access support, plus a memory-mapped I/O window of N input ports (switches/levers) and N output registers (displays), and a free-running cycle counter. It replaces the single-cycle, handshake-free RAM/IO decoder with a valid/ready request/response interface, registered responses, fault reporting and synchronised inputs. It sits between the core's load/store unit and the board I/O.

---
 rtl/banked_mmio_memory_if.sv | 23 ++
 rtl/banked_mmio_memory.sv | 165 ++++++++++++++++
 tb/tb_banked_mmio_memory.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_mmio_memory_if.sv
// Valid/ready request/response bus between the core's load/store unit and banked_mmio_memory.
interface banked_mmio_memory_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_write, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/banked_mmio_memory.sv
// Byte-addressed four-bank RAM with misaligned access, an I/O window of input ports,
// output registers and a free-running cycle counter, behind a valid/ready bus.
module banked_mmio_memory #(
    parameter int ADDR_BITS = 11,
    parameter int IO_BASE   = 1024,
    parameter int N_IN      = 1,
    parameter int N_OUT     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    banked_mmio_memory_if.slave bus,
    input  logic [32*N_IN-1:0]  in_ports_i,
    output logic [32*N_OUT-1:0] out_ports_o
);
    localparam int          DEPTH     = 1 << (ADDR_BITS - 2);
    localparam logic [32:0] RAM_BYTES = 33'(1) << ADDR_BITS;
    localparam logic [31:0] IO_BASE_W = 32'(IO_BASE);
    localparam logic [31:0] IO_SPAN   = 32'h84;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [31:0]          counter_q;
    logic [32*N_IN-1:0]   sync1_q, sync2_q;
    logic [32*N_OUT-1:0]  out_q;
    logic                 pend_ram_q, pend_fault_q;
    logic [31:0]          pend_rdata_q;
    logic [1:0]           rot_q;
    logic [31:0]          rsp_rdata_q;
    logic                 rsp_fault_q;

    logic                 accept;
    logic [31:0]          io_off;
    logic                 io_hit;
    logic [3:0]           io_idx;
    logic                 io_fault;
    logic [31:0]          io_rdata;
    logic [3:0]           lane_touched;
    logic                 ram_fault;
    logic                 fault;
    logic [1:0]           bank_lane [4];
    logic [ADDR_BITS-3:0] bank_addr [4];
    logic [7:0]           bank_wd   [4];
    logic [3:0]           bank_we;
    logic [3:0][7:0]      bank_rd;
    logic [31:0]          ram_rdata;

    assign accept = bus.req_valid && (state_q == ST_IDLE);
    assign io_off = bus.req_addr - IO_BASE_W;
    assign io_hit = (bus.req_addr >= IO_BASE_W) && (io_off < IO_SPAN);
    assign io_idx = io_off[6:3];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        io_fault = 1'b0;
        io_rdata = '0;
        if (bus.req_addr[1:0] != 2'b00) begin
            io_fault = 1'b1;
        end else if (io_off[7]) begin
            io_fault = bus.req_write;
            io_rdata = counter_q;
        end else if (!io_off[2]) begin
            io_fault = ({1'b0, io_idx} >= 5'(N_OUT));
            for (int k = 0; k < N_OUT; k++)
                if (io_idx == 4'(k)) io_rdata = out_q[32*k +: 32];
        end else begin
            io_fault = bus.req_write || ({1'b0, io_idx} >= 5'(N_IN));
            for (int k = 0; k < N_IN; k++)
                if (io_idx == 4'(k)) io_rdata = sync2_q[32*k +: 32];
        end
    end

    always_comb begin
        ram_fault    = 1'b0;
        lane_touched = bus.req_write ? bus.req_be : 4'hF;
        for (int i = 0; i < 4; i++)
            if (lane_touched[i] && (({1'b0, bus.req_addr} + 33'(i)) >= RAM_BYTES)) ram_fault = 1'b1;
    end

    assign fault = io_hit ? io_fault : ram_fault;

    // Bank b serves lane (b - a) mod 4; that lane spills into the next entry when b < a[1:0].
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            bank_lane[b] = 2'(b) - bus.req_addr[1:0];
            bank_addr[b] = bus.req_addr[ADDR_BITS-1:2] + (ADDR_BITS-2)'(2'(b) < bus.req_addr[1:0]);
            bank_wd[b]   = bus.req_wdata[{bank_lane[b], 3'b000} +: 8];
            bank_we[b]   = accept && bus.req_write && !io_hit && !ram_fault && bus.req_be[bank_lane[b]];
        end
    end

    for (genvar b = 0; b < 4; b++) begin : g_bank
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // NOTE: RAM arrays and their read registers have no reset; contents survive rst_n.
        always_ff @(posedge clk) begin
            if (bank_we[b]) mem[bank_addr[b]] <= bank_wd[b];
            if (accept)     rd_q <= mem[bank_addr[b]];
        end

        assign bank_rd[b] = rd_q;
    end

    always_comb begin
        ram_rdata = '0;
        for (int i = 0; i < 4; i++) ram_rdata[8*i +: 8] = bank_rd[rot_q + 2'(i)];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) state_d = ST_READ;
            ST_READ: state_d = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            counter_q    <= '0;
            sync1_q      <= '0;
            sync2_q      <= '0;
            out_q        <= '0;
            pend_ram_q   <= 1'b0;
            pend_fault_q <= 1'b0;
            pend_rdata_q <= '0;
            rot_q        <= '0;
            rsp_rdata_q  <= '0;
            rsp_fault_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_q + 32'd1;
            sync1_q   <= in_ports_i;
            sync2_q   <= sync1_q;
            if (accept) begin
                pend_fault_q <= fault;
                pend_ram_q   <= !io_hit && !bus.req_write && !fault;
                pend_rdata_q <= (io_hit && !bus.req_write && !fault) ? io_rdata : '0;
                rot_q        <= bus.req_addr[1:0];
                if (io_hit && bus.req_write && !fault) begin
                    for (int k = 0; k < N_OUT; k++)
                        for (int i = 0; i < 4; i++)
                            if (io_idx == 4'(k) && bus.req_be[i])
                                out_q[32*k + 8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
            if (state_q == ST_READ) begin
                rsp_fault_q <= pend_fault_q;
                rsp_rdata_q <= pend_ram_q ? ram_rdata : pend_rdata_q;
            end
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_fault = rsp_fault_q;
    assign out_ports_o   = out_q;
endmodule

// File: tb/tb_banked_mmio_memory.sv
// Self-checking bench for banked_mmio_memory: byte-array/queue reference model, per-cycle
// compare process, directed literal checks and randomized traffic.
module tb_banked_mmio_memory;
    localparam int ADDR_BITS = 11;
    localparam int IO_BASE   = 1024;
    localparam int N_IN      = 2;
    localparam int N_OUT     = 2;
    localparam int RAM_BYTES = 1 << ADDR_BITS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [32*N_IN-1:0]   in_ports = '0;
    logic [32*N_OUT-1:0]  out_ports;

    banked_mmio_memory_if bus();

    banked_mmio_memory #(
        .ADDR_BITS (ADDR_BITS),
        .IO_BASE   (IO_BASE),
        .N_IN      (N_IN),
        .N_OUT     (N_OUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .in_ports_i  (in_ports),
        .out_ports_o (out_ports)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed RAM image, output registers, input sample history.
    logic [7:0]          m_mem   [RAM_BYTES];
    bit                  m_known [RAM_BYTES];
    logic [31:0]         m_out   [N_OUT];
    logic [32*N_IN-1:0]  in_hist [$];
    int                  m_cyc   = 0;
    int                  m_stage = 0;
    logic [31:0]         e_rdata = '0;
    logic [31:0]         e_mask  = '1;
    logic                e_fault = 1'b0;

    function automatic logic [32*N_OUT-1:0] m_out_vec();
        logic [32*N_OUT-1:0] v;
        for (int k = 0; k < N_OUT; k++) v[32*k +: 32] = m_out[k];
        return v;
    endfunction

    task automatic model_access();
        logic [31:0]        a, d, off;
        logic [3:0]         be;
        logic               w;
        logic [32*N_IN-1:0] ins;
        int                 k;
        a = bus.req_addr; d = bus.req_wdata; be = bus.req_be; w = bus.req_write;
        e_fault = 1'b0; e_rdata = '0; e_mask = '1;
        ins = (in_hist.size() >= 2) ? in_hist[in_hist.size()-2] : '0;
        off = a - 32'(IO_BASE);
        if (a >= 32'(IO_BASE) && off < 32'h84) begin
            k = int'(off >> 3);
            if (a[1:0] != 2'b00) e_fault = 1'b1;
            else if (off == 32'h80) begin
                if (w) e_fault = 1'b1; else e_rdata = 32'(m_cyc);
            end else if (off[2] == 1'b0) begin
                if (k >= N_OUT) e_fault = 1'b1;
                else if (w) begin
                    for (int i = 0; i < 4; i++) if (be[i]) m_out[k][8*i +: 8] = d[8*i +: 8];
                end else e_rdata = m_out[k];
            end else begin
                if (w || k >= N_IN) e_fault = 1'b1; else e_rdata = ins[32*k +: 32];
            end
        end else begin
            for (int i = 0; i < 4; i++)
                if ((!w || be[i]) && (33'(a) + 33'(i) >= 33'(RAM_BYTES))) e_fault = 1'b1;
            if (!e_fault) begin
                for (int i = 0; i < 4; i++) begin
                    int ad;
                    ad = int'(a) + i;
                    if (w && be[i]) begin
                        m_mem[ad] = d[8*i +: 8];
                        m_known[ad] = 1'b1;
                    end else if (!w) begin
                        e_rdata[8*i +: 8] = m_mem[ad];
                        e_mask[8*i +: 8]  = m_known[ad] ? 8'hFF : 8'h00;
                    end
                end
            end
        end
    endtask

    // Model advance: acceptance, response phase and input sampling on each active edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_stage = 0;
                m_cyc   = 0;
                in_hist.delete();
                for (int k = 0; k < N_OUT; k++) m_out[k] = '0;
            end else begin
                case (m_stage)
                    0: if (bus.req_valid) begin model_access(); m_stage = 1; end
                    1: m_stage = 2;
                    default: if (bus.rsp_ready) m_stage = 0;
                endcase
                in_hist.push_back(in_ports);
                m_cyc++;
            end
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("req_ready", bus.req_ready, m_stage == 0);
            check("rsp_valid", bus.rsp_valid, m_stage == 2);
            check("out_ports", out_ports, m_out_vec());
            if (m_stage == 2) begin
                check("rsp_fault", bus.rsp_fault, e_fault);
                check("rsp_rdata", bus.rsp_rdata & e_mask, e_rdata & e_mask);
            end
        end
    end

    task automatic txn(input logic w, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] d, input int hold,
                       output logic [31:0] rd, output logic f);
        int t;
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_be = be;
        bus.req_addr  = a;    bus.req_wdata = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        t = 0;
        while (!bus.rsp_valid && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (!bus.rsp_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL rsp_timeout: no rsp_valid for addr %h", a);
        end
        repeat (hold) @(negedge clk);
        rd = bus.rsp_rdata;
        f  = bus.rsp_fault;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, c1, c2;
        logic        f;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_be = '0;
        bus.req_addr  = '0;   bus.req_wdata = '0;   bus.rsp_ready = 1'b0;
        #1;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_out_ports", out_ports, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Misaligned RAM writes/reads
        txn(1'b1, 4'hF, 32'd4, 32'h0, 0, rd, f);
        txn(1'b1, 4'hF, 32'd8, 32'h0, 0, rd, f);
        txn(1'b1, 4'hF, 32'd5, 32'hDDCCBBAA, 0, rd, f);
        check("wr5_fault", f, 1'b0);
        txn(1'b0, 4'hF, 32'd4, 32'h0, 0, rd, f);
        check("rd4_data", rd, 32'hCCBBAA00);
        check("rd4_fault", f, 1'b0);
        txn(1'b0, 4'hF, 32'd8, 32'h0, 0, rd, f);
        check("rd8_data", rd, 32'h000000DD);

        // Output register with partial byte enables
        txn(1'b1, 4'b0011, 32'd1024, 32'h12345678, 0, rd, f);
        check("out0_after_wr", out_ports[31:0], 32'h00005678);
        txn(1'b0, 4'hF, 32'd1024, 32'h0, 0, rd, f);
        check("rd1024_data", rd, 32'h00005678);

        // Synchronised inputs
        in_ports = {32'h0BADF00D, 32'hA5A5A5A5};
        repeat (3) @(negedge clk);
        txn(1'b0, 4'hF, 32'd1028, 32'h0, 0, rd, f);
        check("rd1028_a5", rd, 32'hA5A5A5A5);
        txn(1'b0, 4'hF, 32'd1036, 32'h0, 0, rd, f);
        check("rd1036_in1", rd, 32'h0BADF00D);
        in_ports[31:0] = 32'h5A5A5A5A;
        @(negedge clk);
        txn(1'b0, 4'hF, 32'd1028, 32'h0, 0, rd, f);
        check("rd1028_late", rd, 32'hA5A5A5A5);
        txn(1'b0, 4'hF, 32'd1028, 32'h0, 0, rd, f);
        check("rd1028_new", rd, 32'h5A5A5A5A);

        // Faults
        txn(1'b0, 4'hF, 32'd2046, 32'h0, 0, rd, f);
        check("rd2046_fault", f, 1'b1);
        check("rd2046_data", rd, 32'h0);
        txn(1'b1, 4'hF, 32'd1028, 32'hFFFFFFFF, 0, rd, f);
        check("wr1028_fault", f, 1'b1);
        txn(1'b0, 4'hF, 32'd1026, 32'h0, 0, rd, f);
        check("rd1026_fault", f, 1'b1);
        txn(1'b0, 4'hF, 32'd1040, 32'h0, 0, rd, f);
        check("rd_out2_fault", f, 1'b1);
        txn(1'b0, 4'hF, 32'd1044, 32'h0, 0, rd, f);
        check("rd_in2_fault", f, 1'b1);

        // Back-pressure and counter spacing
        txn(1'b0, 4'hF, 32'd4, 32'h0, 4, rd, f);
        check("hold_rd4", rd, 32'hCCBBAA00);
        check("ready_after_hs", bus.req_ready, 1'b1);
        txn(1'b0, 4'hF, 32'd1152, 32'h0, 0, c1, f);
        txn(1'b0, 4'hF, 32'd1152, 32'h0, 0, c2, f);
        check("counter_step", c2 - c1, 32'd3);

        // Reset during response
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'd1024;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", bus.rsp_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rsp_valid", bus.rsp_valid, 1'b0);
        check("async_req_ready", bus.req_ready, 1'b1);
        check("async_out_ports", out_ports, 64'h0);
        check("async_rsp_fault", bus.rsp_fault, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        txn(1'b0, 4'hF, 32'd1152, 32'h0, 0, rd, f);
        check("counter_after_rst", rd, 32'd1);

        // Fill RAM outside the I/O window, then random traffic
        for (int a = 0; a < RAM_BYTES; a += 4)
            if (a < IO_BASE || a >= IO_BASE + 'h84)
                txn(1'b1, 4'hF, 32'(a), $urandom, 0, rd, f);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int          sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 50)      a = 32'($urandom_range(0, RAM_BYTES + 3));
            else if (sel < 85) a = 32'(IO_BASE) + 32'($urandom_range(0, 'h8B));
            else               a = $urandom;
            if ($urandom_range(0, 9) < 3) in_ports = {$urandom, $urandom};
            txn(($urandom_range(0, 9) < 4), 4'($urandom), a, $urandom,
                int'($urandom_range(0, 2)), rd, f);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
